cpu_datapath: RTL and testbench
===============================

# cpu_datapath

Register/bus datapath for the 8-bit teaching CPU: the consumer of every control line the microcode sequencer drives, and the source of the opcode and flags it reads back. Holds the 4-bit PC, MAR, 16×8 RAM, IR, A, B, ALU, flags and output register, all on one 8-bit bus selected by `bus_selector`. The sequencer changes controls on negedge; this block samples them on posedge.

## Interface
Parameters:
- None. Widths are fixed: 8-bit data and 4-bit address.

Ports:
- `clock` in 1: posedge samples controls and updates state.
- `bReset` in 1: reset, asynchronous, active-high.
- `hlt` in 1: halt request.
- `memory_in` in 1: MAR ← bus[3:0].
- `ram_in` in 1: RAM[MAR] ← bus.
- `instruction_in` in 1: IR ← bus.
- `reg_a_in` in 1: A ← bus.
- `reg_b_in` in 1: B ← bus.
- `alu_op` in 2: 0 ADD, 1 SUB, 2 SLL, 3 SRL.
- `out_in` in 1: OUT ← bus.
- `advance_pc` in 1: PC ← PC+1.
- `pc_in` in 1: PC ← bus[3:0].
- `flags_in` in 1: arm the flag capture.
- `bus_selector` in 4: bus source.
- `prog_we` in 1, `prog_addr` in 4, `prog_data` in 8: program-load write port.
- `instruction` out 4: IR[7:4].
- `carry_flag` out 1, `zero_flag` out 1: registered flags.
- `out_value` out 8: OUT register.
- `out_valid` out 1: one-cycle pulse after each OUT load.
- `halted` out 1: sticky halt.
- `pc_dbg` out 4, `reg_a_dbg` out 8: debug views.

## Operation
- Bus sources, selected by `bus_selector`. Bus is combinational.
  - 0: 8'h00.
  - 1: {4'h0, PC}.
  - 2: A.
  - 3: ALU result.
  - 4: B.
  - 5: RAM[MAR].
  - 6: {4'h0, IR[3:0]}.
  - 7–15: 8'h00.
- All enabled loads happen at the same posedge. Several loads in one cycle are legal and all take the same bus value.
- PC:
  - `pc_in` overrides `advance_pc`.
  - Increment wraps 15→0.
- ALU is combinational on A and B and produces an 8-bit result plus carry.
  - ADD: {c,r} = A+B as a 9-bit sum.
  - SUB: {c,r} = A + ~B + 1. c=1 means no borrow (A≥B).
  - zero = (r == 0).
- Flag capture is two-step:
  - `flags_in` at edge k sets `flags_pending`.
  - At edge k+1, carry/zero are loaded from the ALU using that cycle's `alu_op`, A and B, and `flags_pending` clears.
  - This way flags reflect the op executed after B is loaded.
  - If `flags_in` and `flags_pending` are both high, capture happens and pending stays set.
- RAM:
  - RAM is not reset.
  - `prog_we` writes RAM[`prog_addr`] ← `prog_data` at posedge, independent of halt.
  - If `prog_we` and `ram_in` target the same address in one cycle, `prog_we` wins.
- Halt:
  - `hlt` sampled at a posedge sets `halted`.
  - From the next edge on, PC, MAR, IR, A, B, OUT, flags, `flags_pending` and `ram_in` writes are suppressed.
  - Other loads enabled in the `hlt` cycle itself still occur.
  - Only `bReset` clears `halted`.
- `out_valid` is high for exactly the cycle after an OUT load, and is never high while halted.

## Timing
- Reset (async, immediate): all outputs and registers go to 0.
  - Covers PC, MAR, IR, A, B, OUT, `out_valid`, carry, zero, `flags_pending` and `halted`.
  - `instruction` reads 0 (NOP).
- Deasserting reset mid-program resumes from PC=0 with RAM intact.
- Latency:
  - A register load is visible on outputs and the bus immediately after its posedge. The sequencer sees the new `instruction` at the following negedge.
  - RAM read is combinational (MAR→bus same cycle). A RAM write is readable the next cycle.
- Flags become visible 2 posedges after `flags_in` is sampled.

## Configuration
- `CPU_DATAPATH_SHIFT_EN` defined:
  - `alu_op` 2 = SLL: r = A<<1, c = A[7].
  - `alu_op` 3 = SRL: r = A>>1, c = A[0].
- Undefined: `alu_op` 2 and 3 behave exactly as ADD.

## Structure
- Shared package `cpu_pkg` holds:
  - bus-selector encodings (`BUS_NONE` … `BUS_IR`);
  - ALU op encodings;
  - opcode constants (NOP=0 … JZ=8, OUT=14, HLT=15).
- The sequencer and this block both import it.
- One sub-module, `cpu_alu`: combinational, with inputs A, B and `alu_op`, outputs result and carry, and the shift ops under the macro.
- Register file, bus mux, flags and RAM stay in `cpu_datapath`.

## Test plan
- **Reset:** assert `bReset` mid-run with A=8'h55 → all outputs 0 immediately; RAM[3] is unchanged after release.
- **Fetch:** preload RAM[0]=8'h1E; drive sel=1/`memory_in`, then sel=5/`instruction_in`/`advance_pc` → `instruction`=1, IR[3:0]=E, PC=1.
- **ADD with flags:** A=8'hF0, RAM[E]=8'h20; drive sel=5/`reg_b_in`/`flags_in`, then sel=3/`reg_a_in`/`alu_op`=0 → A=8'h10, carry=1, zero=0.
- **SUB to zero:** A=8'h07, B loaded with 8'h07 with `flags_in`, next cycle `alu_op`=1 → A=0, carry=1, zero=1. Repeat with B=8 → carry=0, A=8'hFF.
- **PC behaviour:** PC=15 with `advance_pc` → 0. `pc_in` and `advance_pc` together with bus=8'h09 → PC=9.
- **Halt, OUT and shifts:**
  - `out_in` with A=8'h2A → `out_value`=42 and a single-cycle `out_valid`.
  - `hlt` then `reg_a_in` → `halted`=1 and A unchanged.
  - With `CPU_DATAPATH_SHIFT_EN`: A=8'h81, `alu_op`=2 → r=8'h02, c=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: encodings shared by the microcode sequencer and the datapath
package cpu_pkg;
  typedef enum logic [3:0] {
    BUS_NONE = 4'd0,
    BUS_PC   = 4'd1,
    BUS_A    = 4'd2,
    BUS_ALU  = 4'd3,
    BUS_B    = 4'd4,
    BUS_RAM  = 4'd5,
    BUS_IR   = 4'd6
  } bus_sel_e;
  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_SLL = 2'd2,
    ALU_SRL = 2'd3
  } alu_op_e;
  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_STA = 4'd4;
  localparam logic [3:0] OP_LDI = 4'd5;
  localparam logic [3:0] OP_JMP = 4'd6;
  localparam logic [3:0] OP_JC  = 4'd7;
  localparam logic [3:0] OP_JZ  = 4'd8;
  localparam logic [3:0] OP_OUT = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;
endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational 8-bit ALU; shift ops exist only with CPU_DATAPATH_SHIFT_EN,
// otherwise ops 2 and 3 add.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [1:0] op,
  output logic [7:0] result,
  output logic       carry
);
  logic [8:0] sum;
  always_comb begin
    sum = (op == ALU_SUB) ? {1'b0, a} + {1'b0, ~b} + 9'd1 : {1'b0, a} + {1'b0, b};
`ifdef CPU_DATAPATH_SHIFT_EN
    {carry, result} = (op == ALU_SLL) ? {a[7], a[6:0], 1'b0} :
                      (op == ALU_SRL) ? {a[0], 1'b0, a[7:1]} : sum;
`else
    {carry, result} = sum;
`endif
  end
endmodule

// File: rtl/cpu_datapath.sv
// cpu_datapath: 8-bit teaching-CPU register/bus datapath (PC, MAR, RAM, IR, A, B, ALU,
// flags, OUT) driven by the sequencer's control lines.
module cpu_datapath
  import cpu_pkg::*;
(
  input  logic       clock,
  input  logic       bReset,
  input  logic       hlt,
  input  logic       memory_in,
  input  logic       ram_in,
  input  logic       instruction_in,
  input  logic       reg_a_in,
  input  logic       reg_b_in,
  input  logic [1:0] alu_op,
  input  logic       out_in,
  input  logic       advance_pc,
  input  logic       pc_in,
  input  logic       flags_in,
  input  logic [3:0] bus_selector,
  input  logic       prog_we,
  input  logic [3:0] prog_addr,
  input  logic [7:0] prog_data,
  output logic [3:0] instruction,
  output logic       carry_flag,
  output logic       zero_flag,
  output logic [7:0] out_value,
  output logic       out_valid,
  output logic       halted,
  output logic [3:0] pc_dbg,
  output logic [7:0] reg_a_dbg
);
  logic [3:0] pc, mar;
  logic [7:0] ir, reg_a, reg_b, bus, alu_result;
  logic       alu_carry, flags_pending;
  logic [7:0] ram [16];
  cpu_alu u_alu (
    .a      (reg_a),
    .b      (reg_b),
    .op     (alu_op),
    .result (alu_result),
    .carry  (alu_carry)
  );
  always_comb
    bus = (bus_selector == BUS_PC)  ? {4'h0, pc} :
          (bus_selector == BUS_A)   ? reg_a :
          (bus_selector == BUS_ALU) ? alu_result :
          (bus_selector == BUS_B)   ? reg_b :
          (bus_selector == BUS_RAM) ? ram[mar] :
          (bus_selector == BUS_IR)  ? {4'h0, ir[3:0]} : 8'h00;
  always_ff @(posedge clock or posedge bReset)
    if (bReset) begin
      pc            <= '0;
      mar           <= '0;
      ir            <= '0;
      reg_a         <= '0;
      reg_b         <= '0;
      out_value     <= '0;
      out_valid     <= 1'b0;
      carry_flag    <= 1'b0;
      zero_flag     <= 1'b0;
      flags_pending <= 1'b0;
      halted        <= 1'b0;
    end else begin
      if (hlt) halted <= 1'b1;
      // an OUT load in the hlt cycle still lands, but must not pulse once halted
      out_valid <= out_in && !halted && !hlt;
      if (!halted) begin
        if (flags_pending) begin
          carry_flag <= alu_carry;
          zero_flag  <= (alu_result == 8'h00);
        end
        flags_pending <= flags_in;
        if (memory_in) mar <= bus[3:0];
        if (instruction_in) ir <= bus;
        if (reg_a_in) reg_a <= bus;
        if (reg_b_in) reg_b <= bus;
        if (out_in) out_value <= bus;
        if (pc_in) pc <= bus[3:0];
        else if (advance_pc) pc <= pc + 4'd1;
      end
    end
  // RAM keeps its contents across reset; the program port wins a same-address clash
  always_ff @(posedge clock) begin
    if (ram_in && !halted && !bReset) ram[mar] <= bus;
    if (prog_we) ram[prog_addr] <= prog_data;
  end
  assign instruction = ir[7:4];
  assign pc_dbg      = pc;
  assign reg_a_dbg   = reg_a;
endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed and random stimulus checked every cycle against a behavioural model
module tb_cpu_datapath;
  import cpu_pkg::*;
  logic       clock = 1'b0, bReset;
  logic       hlt, memory_in, ram_in, instruction_in, reg_a_in, reg_b_in, out_in;
  logic       advance_pc, pc_in, flags_in, prog_we;
  logic [1:0] alu_op;
  logic [3:0] bus_selector, prog_addr;
  logic [7:0] prog_data;
  logic [3:0] instruction, pc_dbg;
  logic       carry_flag, zero_flag, out_valid, halted;
  logic [7:0] out_value, reg_a_dbg;
  int n_checks = 0, n_fail = 0;
  logic [3:0] m_pc, m_mar;
  logic [7:0] m_ir, m_a, m_b, m_out;
  logic [7:0] m_ram [16];
  logic       m_c, m_z, m_pend, m_ov, m_halt;

  always #5 clock = ~clock;

  cpu_datapath dut (
    .clock(clock), .bReset(bReset), .hlt(hlt), .memory_in(memory_in), .ram_in(ram_in),
    .instruction_in(instruction_in), .reg_a_in(reg_a_in), .reg_b_in(reg_b_in),
    .alu_op(alu_op), .out_in(out_in), .advance_pc(advance_pc), .pc_in(pc_in),
    .flags_in(flags_in), .bus_selector(bus_selector), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .instruction(instruction),
    .carry_flag(carry_flag), .zero_flag(zero_flag), .out_value(out_value),
    .out_valid(out_valid), .halted(halted), .pc_dbg(pc_dbg), .reg_a_dbg(reg_a_dbg)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {carry, result} straight from the arithmetic definitions
  function automatic logic [8:0] alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int unsigned s;
    s = (op == 2'd1) ? a + 256 - b : a + b;
`ifdef CPU_DATAPATH_SHIFT_EN
    if (op == 2'd2) s = a * 2;
    if (op == 2'd3) s = a / 2 + (a % 2) * 256;
`endif
    return 9'(s);
  endfunction

  function automatic logic [7:0] mbus();
    logic [8:0] al;
    al = alu(alu_op, m_a, m_b);
    case (bus_selector)
      4'd1: return {4'h0, m_pc};
      4'd2: return m_a;
      4'd3: return al[7:0];
      4'd4: return m_b;
      4'd5: return m_ram[m_mar];
      4'd6: return {4'h0, m_ir[3:0]};
      default: return 8'h00;
    endcase
  endfunction

  task automatic check_all();
    chk("pc", 8'(pc_dbg), 8'(m_pc));
    chk("instruction", 8'(instruction), 8'(m_ir[7:4]));
    chk("reg_a", reg_a_dbg, m_a);
    chk("out_value", out_value, m_out);
    chk("out_valid", 8'(out_valid), 8'(m_ov));
    chk("carry", 8'(carry_flag), 8'(m_c));
    chk("zero", 8'(zero_flag), 8'(m_z));
    chk("halted", 8'(halted), 8'(m_halt));
  endtask

  task automatic model_reset();
    m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0; m_out = 0;
    m_c = 0; m_z = 0; m_pend = 0; m_ov = 0; m_halt = 0;
  endtask

  task automatic idle();
    hlt = 0; memory_in = 0; ram_in = 0; instruction_in = 0; reg_a_in = 0; reg_b_in = 0;
    out_in = 0; advance_pc = 0; pc_in = 0; flags_in = 0; prog_we = 0;
    alu_op = 0; bus_selector = 0; prog_addr = 0; prog_data = 0;
  endtask

  task automatic cyc();
    logic [7:0] bv;
    logic [8:0] al;
    logic       en;
    bv = mbus();
    al = alu(alu_op, m_a, m_b);
    en = !m_halt;
    @(posedge clock);
    #1;
    if (ram_in && en) m_ram[m_mar] = bv;
    if (prog_we) m_ram[prog_addr] = prog_data;
    m_ov = out_in && en && !hlt;
    if (en) begin
      if (m_pend) begin
        m_c = al[8];
        m_z = (al[7:0] == 8'h00);
      end
      m_pend = flags_in;
      if (memory_in) m_mar = bv[3:0];
      if (instruction_in) m_ir = bv;
      if (reg_a_in) m_a = bv;
      if (reg_b_in) m_b = bv;
      if (out_in) m_out = bv;
      if (pc_in) m_pc = bv[3:0];
      else if (advance_pc) m_pc = 4'(m_pc + 1);
    end
    if (hlt) m_halt = 1;
    check_all();
  endtask

  task automatic prog(input logic [3:0] addr, input logic [7:0] data);
    idle(); prog_we = 1; prog_addr = addr; prog_data = data; cyc(); idle();
  endtask

  // A <- v through RAM[MAR], clobbering that RAM cell
  task automatic set_a(input logic [7:0] v);
    prog(m_mar, v);
    bus_selector = 4'd5; reg_a_in = 1; cyc(); idle();
  endtask

  task automatic do_reset();
    #2 bReset = 1;
    #1 model_reset();
    check_all();
    #2 bReset = 0;
  endtask

  initial begin
    idle();
    bReset = 1;
    model_reset();
    for (int i = 0; i < 16; i++) m_ram[i] = 8'(i * 17 + 3);
    @(posedge clock); #1;
    check_all();
    chk("reset_pc", 8'(pc_dbg), 8'h00);
    #2 bReset = 0;
    for (int i = 0; i < 16; i++) prog(4'(i), m_ram[i]);
    prog(4'h0, 8'h1E); prog(4'hE, 8'h20); prog(4'h3, 8'h33);
    // fetch
    bus_selector = 4'd1; memory_in = 1; cyc(); idle();
    bus_selector = 4'd5; instruction_in = 1; advance_pc = 1; cyc(); idle();
    chk("fetch_instr", 8'(instruction), 8'h01);
    chk("fetch_pc", 8'(pc_dbg), 8'h01);
    bus_selector = 4'd6; reg_a_in = 1; cyc(); idle();
    chk("fetch_operand", reg_a_dbg, 8'h0E);
    // ADD with flags
    set_a(8'hF0);
    bus_selector = 4'd6; memory_in = 1; cyc(); idle();
    bus_selector = 4'd5; reg_b_in = 1; flags_in = 1; cyc(); idle();
    bus_selector = 4'd3; reg_a_in = 1; alu_op = 2'd0; cyc(); idle();
    chk("add_a", reg_a_dbg, 8'h10);
    chk("add_carry", 8'(carry_flag), 8'h01);
    chk("add_zero", 8'(zero_flag), 8'h00);
    // SUB to zero, then with borrow
    set_a(8'h07);
    bus_selector = 4'd5; reg_b_in = 1; flags_in = 1; cyc(); idle();
    bus_selector = 4'd3; reg_a_in = 1; alu_op = 2'd1; cyc(); idle();
    chk("sub0_a", reg_a_dbg, 8'h00);
    chk("sub0_carry", 8'(carry_flag), 8'h01);
    chk("sub0_zero", 8'(zero_flag), 8'h01);
    set_a(8'h07);
    prog(4'hE, 8'h08);
    bus_selector = 4'd5; reg_b_in = 1; flags_in = 1; cyc(); idle();
    bus_selector = 4'd3; reg_a_in = 1; alu_op = 2'd1; cyc(); idle();
    chk("sub_borrow_a", reg_a_dbg, 8'hFF);
    chk("sub_borrow_carry", 8'(carry_flag), 8'h00);
    chk("sub_borrow_zero", 8'(zero_flag), 8'h00);
    // PC wrap and pc_in priority
    prog(4'hE, 8'h0F);
    bus_selector = 4'd5; pc_in = 1; cyc(); idle();
    chk("pc_load15", 8'(pc_dbg), 8'h0F);
    advance_pc = 1; cyc(); idle();
    chk("pc_wrap", 8'(pc_dbg), 8'h00);
    prog(4'hE, 8'h09);
    bus_selector = 4'd5; pc_in = 1; advance_pc = 1; cyc(); idle();
    chk("pc_in_wins", 8'(pc_dbg), 8'h09);
    // program port beats ram_in on the same address
    prog_we = 1; prog_addr = 4'hE; prog_data = 8'hAA; ram_in = 1; bus_selector = 4'd2; cyc(); idle();
    bus_selector = 4'd5; reg_a_in = 1; cyc(); idle();
    chk("prog_wins", reg_a_dbg, 8'hAA);
    // OUT pulse
    set_a(8'h2A);
    bus_selector = 4'd2; out_in = 1; cyc(); idle();
    chk("out_value", out_value, 8'd42);
    chk("out_valid_hi", 8'(out_valid), 8'h01);
    cyc();
    chk("out_valid_lo", 8'(out_valid), 8'h00);
    // shift (B is 8'h08 here)
    set_a(8'h81);
    flags_in = 1; cyc(); idle();
    bus_selector = 4'd3; alu_op = 2'd2; reg_a_in = 1; cyc(); idle();
`ifdef CPU_DATAPATH_SHIFT_EN
    chk("sll_a", reg_a_dbg, 8'h02);
    chk("sll_carry", 8'(carry_flag), 8'h01);
`else
    chk("op2_add_a", reg_a_dbg, 8'h89);
    chk("op2_add_carry", 8'(carry_flag), 8'h00);
`endif
    // halt
    set_a(8'h55);
    hlt = 1; cyc(); idle();
    bus_selector = 4'd0; reg_a_in = 1; out_in = 1; cyc(); idle();
    chk("halted", 8'(halted), 8'h01);
    chk("halt_a_kept", reg_a_dbg, 8'h55);
    chk("halt_no_valid", 8'(out_valid), 8'h00);
    // async reset mid-run, RAM survives
    do_reset();
    chk("reset_a", reg_a_dbg, 8'h00);
    chk("reset_halted", 8'(halted), 8'h00);
    repeat (3) begin advance_pc = 1; cyc(); idle(); end
    bus_selector = 4'd1; memory_in = 1; cyc(); idle();
    bus_selector = 4'd5; reg_a_in = 1; cyc(); idle();
    chk("ram3_kept", reg_a_dbg, 8'h33);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if (m_halt && $urandom_range(0, 7) == 0) do_reset();
      hlt            = ($urandom_range(0, 299) == 0);
      memory_in      = ($urandom_range(0, 3) == 0);
      ram_in         = ($urandom_range(0, 3) == 0);
      instruction_in = ($urandom_range(0, 3) == 0);
      reg_a_in       = ($urandom_range(0, 2) == 0);
      reg_b_in       = ($urandom_range(0, 2) == 0);
      out_in         = ($urandom_range(0, 3) == 0);
      advance_pc     = ($urandom_range(0, 2) == 0);
      pc_in          = ($urandom_range(0, 5) == 0);
      flags_in       = ($urandom_range(0, 2) == 0);
      prog_we        = ($urandom_range(0, 7) == 0);
      alu_op         = 2'($urandom_range(0, 3));
      bus_selector   = 4'($urandom_range(0, 15));
      prog_addr      = 4'($urandom_range(0, 15));
      prog_data      = 8'($urandom_range(0, 255));
      cyc();
    end
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
